// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: per-instruction sequencer for the MIPS-subset core.
// Reuses one ALU and one memory port across fetch/decode/execute/memory/
// writeback cycles and drives the datapath control encodings plus IR/PC
// write strobes.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> unknown opcode/funct in DECODE enters HALT (halted=1) until reset
//   undefined -> unknown instructions retire like nop, halted is constant 0
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | 0  latch fetched word into IR
// DECODE | 1  register read, dispatch by opcode; nop/unknown retire here
// EXEC   | 2  ALU operation for add/sub/ori/lui
// ALUWB  | 3  write ALU result to register file, advance PC
// ADDR   | 4  effective address = rs + sign-extended imm16
// MEMRD  | 5  data-memory read (lw)
// MEMWB  | 6  write loaded word to rt, advance PC
// MEMWR  | 7  data-memory write (sw), advance PC
// BRANCH | 8  compare rs/rt, PC takes branch target when equal
// JUMP   | 9  jal (link to $31) or jr
// HALT   | 10 illegal instruction trap, frozen until reset
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        irWE,
  output logic        pcWE,
  output logic [2:0]  aluOp,
  output logic        aluSrc,
  output logic        usExt,
  output logic [1:0]  regDesCtrl,
  output logic [1:0]  regDataCtrl,
  output logic        regWE,
  output logic        dmWE,
  output logic        dmRE,
  output logic [2:0]  nextPCop,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_ADDR   = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef ILLEGAL_TRAP_EN
    ,
    S_HALT   = 4'd10
`endif
  } state_t;

  state_t st;

  logic [5:0] op;
  logic [5:0] fn;
  logic is_nop, is_rtype, is_add, is_sub, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
  logic is_alu, is_mem, is_jump;
  logic [2:0] exec_op;
  logic exec_src, exec_us;

  assign op       = instr[31:26];
  assign fn       = instr[5:0];
  // nop is the all-zero word; it shares op 000000 with R-type but is not add/sub/jr
  assign is_nop   = (instr == 32'd0);
  assign is_rtype = (op == 6'b000000);
  assign is_add   = is_rtype && (fn == 6'b100000);
  assign is_sub   = is_rtype && (fn == 6'b100010);
  assign is_jr    = is_rtype && (fn == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_jal   = (op == 6'b000011);
  assign is_alu   = is_add | is_sub | is_ori | is_lui;
  assign is_mem   = is_lw | is_sw;
  assign is_jump  = is_jal | is_jr;

  // ALU controls shared by EXEC and ALUWB so the result stays stable through writeback
  assign exec_op  = is_sub ? 3'b001 : is_ori ? 3'b010 : is_lui ? 3'b011 : 3'b000;
  assign exec_src = is_ori | is_lui;
  assign exec_us  = is_ori;

  // State register: sequence through the per-instruction cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          if (is_alu)       st <= S_EXEC;
          else if (is_mem)  st <= S_ADDR;
          else if (is_beq)  st <= S_BRANCH;
          else if (is_jump) st <= S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          else if (!is_nop) st <= S_HALT;
`endif
          else              st <= S_FETCH;
        end
        S_EXEC:   st <= S_ALUWB;
        S_ALUWB:  st <= S_FETCH;
        S_ADDR:   st <= is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  st <= S_MEMWB;
        S_MEMWB:  st <= S_FETCH;
        S_MEMWR:  st <= S_FETCH;
        S_BRANCH: st <= S_FETCH;
        S_JUMP:   st <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_HALT:   st <= S_HALT;
`endif
        default:  st <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; reset forces everything quiet
  always_comb begin
    irWE        = 1'b0;
    pcWE        = 1'b0;
    aluOp       = 3'b000;
    aluSrc      = 1'b0;
    usExt       = 1'b0;
    regDesCtrl  = 2'b00;
    regDataCtrl = 2'b00;
    regWE       = 1'b0;
    dmWE        = 1'b0;
    dmRE        = 1'b0;
    nextPCop    = 3'b000;
    if (!reset) begin
      case (st)
        S_FETCH: irWE = 1'b1;
        S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          pcWE = is_nop;
`else
          pcWE = !(is_alu | is_mem | is_beq | is_jump);
`endif
        end
        S_EXEC: begin
          aluOp  = exec_op;
          aluSrc = exec_src;
          usExt  = exec_us;
        end
        S_ALUWB: begin
          aluOp      = exec_op;
          aluSrc     = exec_src;
          usExt      = exec_us;
          regWE      = 1'b1;
          regDesCtrl = is_rtype ? 2'b01 : 2'b00;
          pcWE       = 1'b1;
        end
        S_ADDR: begin
          aluSrc = 1'b1;
        end
        S_MEMRD: begin
          aluSrc = 1'b1;
          dmRE   = 1'b1;
        end
        S_MEMWB: begin
          regWE       = 1'b1;
          regDataCtrl = 2'b01;
          pcWE        = 1'b1;
        end
        S_MEMWR: begin
          aluSrc = 1'b1;
          dmWE   = 1'b1;
          pcWE   = 1'b1;
        end
        S_BRANCH: begin
          aluOp    = 3'b001;
          pcWE     = 1'b1;
          nextPCop = zero ? 3'b001 : 3'b000;
        end
        S_JUMP: begin
          pcWE = 1'b1;
          if (is_jal) begin
            regWE       = 1'b1;
            regDesCtrl  = 2'b10;
            regDataCtrl = 2'b10;
            nextPCop    = 3'b010;
          end else begin
            nextPCop = 3'b011;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = st;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (st == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
